// File: rtl/wd_fault_logger.sv
// Watchdog fault logger: turns rising edges on the watchdog outputs into
// timestamped records held in a first-word-fall-through FIFO. Records
// that arrive while the FIFO is full are counted rather than stored.
module wd_fault_logger #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WDFAIL,
  input  logic [2:0]               FLSTAT,
  input  logic                     BROWNOUT,
  input  logic                     RSTOUT,
  input  logic                     RD_REQ,
  input  logic                     CLR,
  output logic                     RD_VALID,
  output logic [TS_W+7:0]          RD_DATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     OVERFLOW,
  output logic [7:0]               DROP_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = TS_W + 8;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts;
  logic            wd_q, bo_q, rs_q;
  logic            wd_qq, bo_qq, rs_qq;
  logic [2:0]      flstat_q;
  logic            e_wd, e_bo, e_rs, evt;
  logic [RW-1:0]   record;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, drop;

  // Free-running timestamp; deliberately untouched by CLR.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ts <= '0;
    else      ts <= ts + 1'b1;
  end

  // Two-stage input history for rising-edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd_q     <= 1'b0;
      bo_q     <= 1'b0;
      rs_q     <= 1'b0;
      flstat_q <= '0;
      wd_qq    <= 1'b0;
      bo_qq    <= 1'b0;
      rs_qq    <= 1'b0;
    end else begin
      wd_q     <= WDFAIL;
      bo_q     <= BROWNOUT;
      rs_q     <= RSTOUT;
      flstat_q <= FLSTAT;
      wd_qq    <= wd_q;
      bo_qq    <= bo_q;
      rs_qq    <= rs_q;
    end
  end

  // Edge terms, record assembly and FIFO write/read qualification.
  always_comb begin
    e_wd   = wd_q & ~wd_qq;
    e_bo   = bo_q & ~bo_qq;
    e_rs   = rs_q & ~rs_qq;
    evt    = e_wd | e_bo | e_rs;
    record = {ts, flstat_q, e_bo, e_wd, e_rs, 2'b00};
    pop    = RD_REQ & RD_VALID & ~CLR;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push   = evt & ~CLR & (~FULL | pop);
    drop   = evt & ~CLR & FULL & ~pop;
  end

  // Record storage; no reset needed since RD_DATA is masked when empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= record;
  end

  // Pointers, occupancy and overflow bookkeeping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else if (CLR) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        OVERFLOW <= 1'b1;
        if (DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
      end
    end
  end

  // Status and fall-through head output.
  always_comb begin
    COUNT    = count;
    FULL     = (count == DEPTH_C);
    RD_VALID = (count != '0);
    RD_DATA  = RD_VALID ? mem[rd_ptr] : '0;
  end

endmodule

// File: doc/wd_fault_logger.md
Name: wd_fault_logger

Overview:
- Sits directly downstream of the watchdog top level.
- Consumes its RSTOUT, WDFAIL, FLSTAT and BROWNOUT outputs and timestamps every new fault event.
- Stores each event as a record in a small first-word-fall-through FIFO.
- Supervisory firmware drains records through a valid/request handshake; overflow is counted, never silently lost.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
TS_W, 16, timestamp counter width; record width is TS_W+8

Ports:
CLK  in  1  system clock, same domain as the watchdog
RST  in  1  asynchronous, active-low reset
WDFAIL  in  1  watchdog failure flag
FLSTAT  in  3  watchdog failure status code
BROWNOUT  in  1  brownout detector flag
RSTOUT  in  1  watchdog reset request
RD_REQ  in  1  pop head record; honoured only while RD_VALID=1
CLR  in  1  synchronous clear of FIFO, OVERFLOW and DROP_CNT
RD_VALID  out  1  FIFO not empty
RD_DATA  out  TS_W+8  head record
COUNT  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
FULL  out  1  COUNT==DEPTH
OVERFLOW  out  1  sticky: at least one record dropped since reset/CLR
DROP_CNT  out  8  dropped records, saturates at 255

Behaviour:
- Reset (RST=0, asynchronous):
  - FIFO pointers, COUNT, timestamp, DROP_CNT, OVERFLOW and input history registers all cleared to 0.
  - Outputs: RD_VALID=0, RD_DATA=0, FULL=0.
- Timestamp: free-running TS_W-bit counter, +1 every cycle, wraps 2^TS_W-1 -> 0. Not affected by CLR.
- Input stage:
  - WDFAIL, BROWNOUT, RSTOUT and FLSTAT are registered once (_q).
  - The three flags are registered again (_qq).
  - Edge terms: e_wd = WDFAIL_q & ~WDFAIL_qq; e_bo and e_rs defined the same way.
  - Event cycle: any edge term is 1.
- Record layout:
  - [TS_W+7:8] = timestamp value in the event cycle
  - [7:5] = FLSTAT_q
  - [4] = e_bo, [3] = e_wd, [2] = e_rs
  - [1:0] = 2'b00
- Simultaneous edges produce ONE record with several flag bits set.
- Latency: input rises before clock edge k -> event cycle k -> record written at edge k+1. RD_VALID rises after edge k+1 if the FIFO was empty.
- Input already high when reset is released: logged as an event, since _qq resets to 0. This is intentional, so faults present at power-up are recorded.
- FIFO is first-word fall-through: RD_DATA always shows the head entry. RD_DATA=0 when empty.
- Read: RD_REQ=1 and RD_VALID=1 at an edge pops the head. RD_REQ while empty is ignored and causes no underflow.
- Write-side cases:
  - Write, not full: push.
  - Write, full, no pop: record dropped; OVERFLOW<=1; DROP_CNT<=min(DROP_CNT+1,255).
  - Write and pop in the same cycle (including when full): both happen; COUNT unchanged; no drop.
  - Pop, no write: COUNT-1.
- Pointer wrap: read/write pointers are modulo DEPTH. COUNT is kept explicitly, so full and empty are unambiguous.
- CLR:
  - Takes priority over everything in its cycle: empties the FIFO and zeroes OVERFLOW and DROP_CNT.
  - Any event or RD_REQ in the CLR cycle is discarded.
  - Edge history still updates, so a held level does not re-trigger.
- Held inputs generate exactly one record per rising edge. Falling edges are not logged.

Test Plan:
- Reset release with all inputs low, then a WDFAIL pulse of 3 cycles starting at cycle 10 -> exactly one record, RD_VALID high 2 cycles after the rise; RD_DATA[3]=1, [4]=0, [2]=0, [7:5]=FLSTAT; timestamp field = 11.
- BROWNOUT and RSTOUT rise on the same cycle with FLSTAT=3'b101 -> one record, flag bits [4] and [2] set, [7:5]=5; COUNT=1.
- Ten WDFAIL pulses, no reads, DEPTH=8 -> COUNT=8, FULL=1, OVERFLOW=1, DROP_CNT=2. The eight stored timestamps are strictly increasing and in arrival order.
- FIFO full, event and RD_REQ on the same cycle -> oldest record popped, new record appended, COUNT stays 8, DROP_CNT unchanged.
- Timestamp wrap: force a pulse so its event cycle hits counter 0xFFFF, then another 2 cycles later -> records carry 0xFFFF and 0x0001, in that order.
- WDFAIL held high through reset release; CLR asserted on the same cycle as a BROWNOUT edge; RD_REQ issued while empty:
  - Exactly one power-up WDFAIL record.
  - After CLR: COUNT=0, OVERFLOW=0, DROP_CNT=0, no BROWNOUT record.
  - RD_REQ while empty causes no change.
